// File: rtl/vram_arb_pkg.sv
// Shared constants and state encoding for the VRAM write arbiter.
package vram_arb_pkg;

    localparam int SCREEN_W     = 320;
    localparam int SCREEN_H     = 240;
    localparam int X_WIDTH      = 9;
    localparam int Y_WIDTH      = 8;
    localparam int COLOUR_WIDTH = 6;

    localparam int LAST_X = SCREEN_W - 1;
    localparam int LAST_Y = SCREEN_H - 1;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/vram_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
            if (grant != 2'b00) begin
                last_grant_d = grant[1];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the VGA adapter pixel-write port between two drawing engines and a
// full-screen clear sequencer; one registered pixel per cycle, off-screen writes dropped.
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int SCREEN_W     = vram_arb_pkg::SCREEN_W,
    parameter int SCREEN_H     = vram_arb_pkg::SCREEN_H,
    parameter int X_WIDTH      = vram_arb_pkg::X_WIDTH,
    parameter int Y_WIDTH      = vram_arb_pkg::Y_WIDTH,
    parameter int COLOUR_WIDTH = vram_arb_pkg::COLOUR_WIDTH
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    clear_start,
    input  logic [COLOUR_WIDTH-1:0] clear_colour,
    output logic                    clear_busy,
    output logic                    clear_done,
    input  logic                    req0_valid,
    input  logic [X_WIDTH-1:0]      req0_x,
    input  logic [Y_WIDTH-1:0]      req0_y,
    input  logic [COLOUR_WIDTH-1:0] req0_colour,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [X_WIDTH-1:0]      req1_x,
    input  logic [Y_WIDTH-1:0]      req1_y,
    input  logic [COLOUR_WIDTH-1:0] req1_colour,
    output logic                    req1_ready,
    output logic [X_WIDTH-1:0]      vga_x,
    output logic [Y_WIDTH-1:0]      vga_y,
    output logic [COLOUR_WIDTH-1:0] vga_colour,
    output logic                    vga_plot
);

    localparam logic [X_WIDTH-1:0] SWEEP_LAST_X = X_WIDTH'(SCREEN_W - 1);
    localparam logic [Y_WIDTH-1:0] SWEEP_LAST_Y = Y_WIDTH'(SCREEN_H - 1);
    localparam logic [X_WIDTH:0]   X_LIMIT      = (X_WIDTH + 1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0]   Y_LIMIT      = (Y_WIDTH + 1)'(SCREEN_H);

    state_e                  state_q, state_d;
    logic [X_WIDTH-1:0]      cx_q, cx_d;
    logic [Y_WIDTH-1:0]      cy_q, cy_d;
    logic [COLOUR_WIDTH-1:0] fill_q, fill_d;
    logic [X_WIDTH-1:0]      vga_x_q, vga_x_d;
    logic [Y_WIDTH-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_WIDTH-1:0] vga_colour_q, vga_colour_d;
    logic                    vga_plot_q, vga_plot_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    arb_en;
    logic [1:0]              grant;
    logic [X_WIDTH-1:0]      sel_x;
    logic [Y_WIDTH-1:0]      sel_y;
    logic [COLOUR_WIDTH-1:0] sel_colour;

    // A pending clear outranks both engines, and reset holds both readies low.
    assign arb_en = resetn && (state_q == ARB) && !clear_start;

    rr_arbiter2 u_rr (
        .clock  (clock),
        .resetn (resetn),
        .enable (arb_en),
        .req    ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign sel_x      = grant[1] ? req1_x      : req0_x;
    assign sel_y      = grant[1] ? req1_y      : req0_y;
    assign sel_colour = grant[1] ? req1_colour : req0_colour;

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        fill_d       = fill_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            ARB: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                    fill_d  = clear_colour;
                end else if (grant != 2'b00) begin
                    vga_x_d      = sel_x;
                    vga_y_d      = sel_y;
                    vga_colour_d = sel_colour;
                    vga_plot_d   = ({1'b0, sel_x} < X_LIMIT) && ({1'b0, sel_y} < Y_LIMIT);
                end
            end
            CLEAR: begin
                vga_x_d      = cx_q;
                vga_y_d      = cy_q;
                vga_colour_d = fill_q;
                vga_plot_d   = 1'b1;
                if (cx_q == SWEEP_LAST_X) begin
                    cx_d = '0;
                    if (cy_q == SWEEP_LAST_Y) begin
                        state_d = ARB;
                        done_d  = 1'b1;
                    end else begin
                        cy_d = cy_q + Y_WIDTH'(1);
                    end
                end else begin
                    cx_d = cx_q + X_WIDTH'(1);
                end
            end
            default: state_d = ARB;
        endcase

        // Busy tracks the state being entered, so it drops with the done pulse.
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ARB;
            cx_q         <= '0;
            cy_q         <= '0;
            fill_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            fill_q       <= fill_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench: expected pixels queued on transfer, popped when vga_plot fires;
// full clear sweep tracked by a raster model.
module tb_vram_write_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       clear_start;
    logic [5:0] clear_colour;
    logic       clear_busy;
    logic       clear_done;
    logic       req0_valid, req1_valid;
    logic [8:0] req0_x, req1_x;
    logic [7:0] req0_y, req1_y;
    logic [5:0] req0_colour, req1_colour;
    logic       req0_ready, req1_ready;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [5:0] vga_colour;
    logic       vga_plot;

    always #5 clock = ~clock;

    vram_write_arbiter dut (
        .clock        (clock),
        .resetn       (resetn),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .req0_valid   (req0_valid),
        .req0_x       (req0_x),
        .req0_y       (req0_y),
        .req0_colour  (req0_colour),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_x       (req1_x),
        .req1_y       (req1_y),
        .req1_colour  (req1_colour),
        .req1_ready   (req1_ready),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot)
    );

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [5:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit         mon_en = 1'b0;
    bit         sweep_mode = 1'b0;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [5:0] sweep_colour;
    int         sweep_plots, sweep_bad, busy_cycles, done_count, ready_in_clear;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pix(input logic [8:0] x, input logic [7:0] y, input logic [5:0] c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        exp_q.push_back(p);
    endtask

    task automatic sweep_init(input logic [5:0] colour);
        ex             = '0;
        ey             = '0;
        sweep_colour   = colour;
        sweep_plots    = 0;
        sweep_bad      = 0;
        busy_cycles    = 0;
        ready_in_clear = 0;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (clear_busy === 1'b1) busy_cycles++;
            if (clear_done === 1'b1) done_count++;
            if (clear_busy === 1'b1 && (req0_ready !== 1'b0 || req1_ready !== 1'b0)) ready_in_clear++;
            if (vga_plot === 1'b1) begin
                if (sweep_mode) begin
                    sweep_plots++;
                    if (vga_x !== ex || vga_y !== ey || vga_colour !== sweep_colour) sweep_bad++;
                    if (clear_done === 1'b1 && !(ex == 9'd319 && ey == 8'd239)) sweep_bad++;
                    if (ex == 9'd319) begin
                        ex = '0;
                        ey = ey + 8'd1;
                    end else begin
                        ex = ex + 9'd1;
                    end
                    if (clear_done === 1'b1) sweep_mode = 1'b0;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_plot", 32'(vga_plot), 32'd0);
                end else begin
                    pix_t p;
                    p = exp_q.pop_front();
                    chk("plot_x", 32'(vga_x), 32'(p.x));
                    chk("plot_y", 32'(vga_y), 32'(p.y));
                    chk("plot_colour", 32'(vga_colour), 32'(p.c));
                end
            end else if (clear_done === 1'b1) begin
                sweep_bad++;
            end
        end
    end

    initial begin
        pix_t p0[3];
        pix_t p1[3];
        int   i0, i1, done_before;
        bit   found;

        resetn       = 1'b0;
        clear_start  = 1'b0;
        clear_colour = '0;
        req0_valid   = 1'b1;
        req1_valid   = 1'b1;
        req0_x = '0; req0_y = '0; req0_colour = '0;
        req1_x = '0; req1_y = '0; req1_colour = '0;
        done_count = 0;
        sweep_init(6'h00);

        // Reset state.
        cyc();
        cyc();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_x", 32'(vga_x), 32'd0);
        chk("rst_colour", 32'(vga_colour), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resetn     = 1'b1;
        mon_en     = 1'b1;
        cyc();

        // Single on-screen pixel from requester 0, one-cycle latency.
        req0_x = 9'd10; req0_y = 8'd20; req0_colour = 6'h3F; req0_valid = 1'b1;
        #1;
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        chk("t1_ready1", 32'(req1_ready), 32'd0);
        expect_pix(9'd10, 8'd20, 6'h3F);
        cyc();
        req0_valid = 1'b0;
        chk("t1_plot", 32'(vga_plot), 32'd1);
        chk("t1_x", 32'(vga_x), 32'd10);
        chk("t1_y", 32'(vga_y), 32'd20);
        chk("t1_colour", 32'(vga_colour), 32'h3F);
        cyc();
        chk("idle_plot", 32'(vga_plot), 32'd0);
        chk("idle_hold_x", 32'(vga_x), 32'd10);

        // Off-screen pixels from requester 1: accepted, never plotted.
        req1_x = 9'd320; req1_y = 8'd5; req1_colour = 6'h01; req1_valid = 1'b1;
        #1;
        chk("off1_ready1", 32'(req1_ready), 32'd1);
        chk("off1_ready0", 32'(req0_ready), 32'd0);
        cyc();
        chk("off1_plot", 32'(vga_plot), 32'd0);
        req1_x = 9'd5; req1_y = 8'd240;
        #1;
        chk("off2_ready1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        chk("off2_plot", 32'(vga_plot), 32'd0);
        chk("off2_x", 32'(vga_x), 32'd5);
        chk("off2_y", 32'(vga_y), 32'd240);

        // Both valid: last grant was 1, so grants go 0,1,0,1.
        p0[0] = {9'd100, 8'd1, 6'h01}; p0[1] = {9'd101, 8'd2, 6'h02}; p0[2] = {9'd0, 8'd0, 6'h00};
        p1[0] = {9'd200, 8'd3, 6'h03}; p1[1] = {9'd201, 8'd4, 6'h04}; p1[2] = {9'd0, 8'd0, 6'h00};
        i0 = 0;
        i1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) chk("rr_plot_run", 32'(vga_plot), 32'd1);
            {req0_x, req0_y, req0_colour} = p0[i0];
            {req1_x, req1_y, req1_colour} = p1[i1];
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            chk("rr_ready0", 32'(req0_ready), 32'((i % 2) == 0));
            chk("rr_ready1", 32'(req1_ready), 32'((i % 2) == 1));
            if ((i % 2) == 0) begin
                exp_q.push_back(p0[i0]);
                i0++;
            end else begin
                exp_q.push_back(p1[i1]);
                i1++;
            end
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_plot_last", 32'(vga_plot), 32'd1);
        cyc();
        chk("rr_plot_end", 32'(vga_plot), 32'd0);

        // Full-screen clear, with requester 0 waiting and a stray restart mid-sweep.
        sweep_init(6'h00);
        done_before  = done_count;
        clear_colour = 6'h00;
        clear_start  = 1'b1;
        req0_x = 9'd7; req0_y = 8'd8; req0_colour = 6'h15; req0_valid = 1'b1;
        #1;
        chk("clr_ready0", 32'(req0_ready), 32'd0);
        chk("clr_ready1", 32'(req1_ready), 32'd0);
        sweep_mode = 1'b1;
        cyc();
        clear_start  = 1'b0;
        clear_colour = 6'h2A;
        chk("clr_busy_rise", 32'(clear_busy), 32'd1);
        found = 1'b0;
        for (int n = 0; n < 80000; n++) begin
            cyc();
            if (clear_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            clear_start  = (n == 30000);
            clear_colour = (n == 30000) ? 6'h3F : 6'h2A;
        end
        clear_start = 1'b0;
        chk("clr_done_seen", 32'(found), 32'd1);
        chk("clr_last_x", 32'(vga_x), 32'd319);
        chk("clr_last_y", 32'(vga_y), 32'd239);
        chk("clr_last_plot", 32'(vga_plot), 32'd1);
        chk("clr_last_colour", 32'(vga_colour), 32'h00);
        chk("clr_busy_fall", 32'(clear_busy), 32'd0);
        chk("post_clr_ready0", 32'(req0_ready), 32'd1);
        expect_pix(9'd7, 8'd8, 6'h15);
        cyc();
        req0_valid = 1'b0;
        chk("post_clr_plot", 32'(vga_plot), 32'd1);
        cyc();
        chk("clr_plot_count", 32'(sweep_plots), 32'd76800);
        chk("clr_raster_errs", 32'(sweep_bad), 32'd0);
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd76800);
        chk("clr_done_count", 32'(done_count - done_before), 32'd1);
        chk("clr_ready_leak", 32'(ready_in_clear), 32'd0);

        // Reset in the middle of a sweep, then normal service resumes.
        sweep_init(6'h11);
        clear_colour = 6'h11;
        clear_start  = 1'b1;
        req0_x = 9'd30; req0_y = 8'd40; req0_colour = 6'h0C; req0_valid = 1'b1;
        req1_x = 9'd50; req1_y = 8'd60; req1_colour = 6'h0D; req1_valid = 1'b1;
        sweep_mode = 1'b1;
        cyc();
        clear_start = 1'b0;
        repeat (5 * 320 + 10) cyc();
        chk("mid_busy", 32'(clear_busy), 32'd1);
        done_before = done_count;
        resetn = 1'b0;
        cyc();
        sweep_mode = 1'b0;
        chk("abort_busy", 32'(clear_busy), 32'd0);
        chk("abort_plot", 32'(vga_plot), 32'd0);
        chk("abort_done", 32'(clear_done), 32'd0);
        chk("abort_ready0", 32'(req0_ready), 32'd0);
        chk("abort_raster_errs", 32'(sweep_bad), 32'd0);
        resetn = 1'b1;
        #1;
        chk("rst_rr_ready0", 32'(req0_ready), 32'd1);
        chk("rst_rr_ready1", 32'(req1_ready), 32'd0);
        expect_pix(9'd30, 8'd40, 6'h0C);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("rst_rr2_ready1", 32'(req1_ready), 32'd1);
        expect_pix(9'd50, 8'd60, 6'h0D);
        cyc();
        req1_valid = 1'b0;
        chk("rst_rr2_plot", 32'(vga_plot), 32'd1);
        repeat (3) cyc();
        chk("abort_no_done", 32'(done_count - done_before), 32'd0);
        chk("abort_busy_idle", 32'(clear_busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
